x1spi_slv: RTL and testbench
============================

X1SPI_SLV -- requirements
Module: x1spi_slv

Parameters
REQ-001 The block SHALL have parameter RD_CMD, default 8'hAA: the only command that starts a read.
REQ-002 The block SHALL have parameter DUM_NUM, default 3: the number of dummy bytes between the address and the data phase (0-7).

Interface
REQ-003 i_clk  input  1  system clock; all logic is in this domain.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_sclk  input  1  SPI clock from the master, asynchronous; mode 0.
REQ-006 i_cs_n  input  1  chip select from the master, active-low, asynchronous.
REQ-007 i_si  input  1  MOSI from the master, asynchronous.
REQ-008 o_so  output  1  MISO to the master.
REQ-009 o_so_oe  output  1  MISO output enable; 1 only in DATA state.
REQ-010 o_cmd  output  8  captured command byte.
REQ-011 o_addr  output  24  captured address, MSB first.
REQ-012 o_hdr_vld  output  1  one-cycle pulse when a RD_CMD command plus address is complete.
REQ-013 o_rd_req  output  1  one-cycle pulse requesting the next read byte.
REQ-014 i_rd_data  input  8  read byte supplied by the user.
REQ-015 o_busy  output  1  high while the state is not IDLE.
REQ-016 o_end  output  1  one-cycle pulse when cs_n deasserts with the state not IDLE.

Function
REQ-017 i_sclk, i_cs_n and i_si SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk (rise = 0->1, fall = 1->0).
REQ-018 Correct operation SHALL require an i_clk frequency of at least 4x the sclk frequency; slower i_clk is unsupported.
REQ-019 States SHALL be IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-020 IDLE->CMD on a synchronized cs_n falling edge; the bit counter SHALL clear to 0 on entry.
REQ-021 In all states except IDLE and IGNORE, i_si SHALL be sampled MSB-first on each sclk rise.
REQ-022 CMD: after 8 rises, o_cmd SHALL be loaded; the next state SHALL be ADDR if o_cmd equals RD_CMD, else IGNORE.
REQ-023 ADDR: after 24 rises, o_addr SHALL be loaded and o_hdr_vld SHALL pulse in the same cycle.
REQ-024 After ADDR, the next state SHALL be DUMMY if DUM_NUM>0, else DATA.
REQ-025 o_rd_req SHALL also pulse in the ADDR-completion cycle, requesting the first data byte.
REQ-026 DUMMY: the block SHALL count DUM_NUM*8 rises, ignoring i_si, then enter DATA.
REQ-027 DATA: on the first sclk fall in DATA, i_rd_data SHALL be loaded into an 8-bit shift register and its MSB driven on o_so.
REQ-028 In DATA, each later fall SHALL shift the next bit out; after 8 bits the next fall SHALL reload from i_rd_data.
REQ-029 In DATA, o_rd_req SHALL pulse one cycle after each load, requesting the following byte.
REQ-030 Data SHALL stream without limit until cs_n deasserts.
REQ-031 The user SHALL hold i_rd_data valid from no later than 7 sclk periods after an o_rd_req pulse until the next load.
REQ-032 IGNORE: o_so_oe SHALL stay 0 and no further pulses SHALL be issued until cs_n deasserts.
REQ-033 A synchronized cs_n rise in any state SHALL force IDLE next cycle, clear the counters and pulse o_end.
REQ-034 On a cs_n rise, o_cmd and o_addr SHALL hold their last values.
REQ-035 A transaction truncated mid-byte SHALL not update o_cmd or o_addr and SHALL not pulse o_hdr_vld.
REQ-036 If a cs_n rise and an sclk edge are detected in the same cycle, the cs_n rise SHALL win.
REQ-037 Outside DATA, o_so SHALL be 0.

Reset
REQ-038 While i_rst=1: state IDLE; o_so=0, o_so_oe=0, o_cmd=0, o_addr=0, o_hdr_vld=0, o_rd_req=0, o_busy=0, o_end=0; synchronizers preset cs_n=1 and sclk=0.
REQ-039 After i_rst deasserts with cs_n already low, the block SHALL stay IDLE until cs_n goes high and then low again.

Verification
REQ-040 i_clk 100 MHz, sclk 10 MHz; master sends cmd AA, addr 555555, 24 dummy clocks; user answers 5A then C3 -> o_cmd=AA, o_addr=555555, one o_hdr_vld, MISO bits 01011010 11000011, o_rd_req pulses=3, o_end=1 at cs_n rise.
REQ-041 Cmd 03 -> o_cmd=03, state IGNORE, o_hdr_vld=0, o_so_oe=0 throughout, o_end at cs_n rise.
REQ-042 cs_n raised after 12 address bits -> o_addr unchanged (0 after reset), no o_hdr_vld, o_end pulse, IDLE.
REQ-043 DUM_NUM=0 -> DATA entered immediately after address bit 23; first MISO bit driven on the next sclk fall.
REQ-044 i_rst pulsed mid-DATA -> all outputs return to REQ-038 values; the following full transaction passes as in REQ-040.

Source files
------------

// File: rtl/x1spi_slv.sv
// SPI mode-0 read slave: command, 24-bit address, dummy bytes, then streamed
// read data, all handled in the i_clk domain behind 2-flop synchronizers.
module x1spi_slv #(
   parameter logic [7:0]  RD_CMD  = 8'hAA,
   parameter int unsigned DUM_NUM = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sclk,
   input  logic        i_cs_n,
   input  logic        i_si,
   output logic        o_so,
   output logic        o_so_oe,
   output logic [7:0]  o_cmd,
   output logic [23:0] o_addr,
   output logic        o_hdr_vld,
   output logic        o_rd_req,
   input  logic [7:0]  i_rd_data,
   output logic        o_busy,
   output logic        o_end
);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DUMMY, DATA, IGNORE
   } state_t;

   localparam logic [5:0] DUM_LAST = 6'(DUM_NUM * 8 - 1);

   state_t      state_q;
   logic [2:0]  sclk_q;
   logic [2:0]  cs_q;
   logic [1:0]  si_q;
   logic [1:0]  vld_q;
   logic        arm_q;
   logic [5:0]  cnt_q;
   logic [22:0] sh_q;
   logic [7:0]  out_q;
   logic        ld_q;
   logic        so_q;
   logic        oe_q;
   logic [7:0]  cmd_q;
   logic [23:0] addr_q;
   logic        hdr_q;
   logic        rd_q;
   logic        busy_q;
   logic        end_q;

   logic        sclk_rise;
   logic        sclk_fall;
   logic        cs_fall;
   logic        cs_rise;
   logic [23:0] shin;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   // Only arm on a cs_n seen high after the synchronizer holds real samples,
   // so a cs_n already low when reset releases cannot start a transfer.
   assign cs_fall   = arm_q & ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign shin      = {sh_q, si_q[1]};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         sclk_q  <= 3'b000;
         cs_q    <= 3'b111;
         si_q    <= 2'b00;
         vld_q   <= 2'b00;
         arm_q   <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
         out_q   <= '0;
         ld_q    <= 1'b0;
         so_q    <= 1'b0;
         oe_q    <= 1'b0;
         cmd_q   <= '0;
         addr_q  <= '0;
         hdr_q   <= 1'b0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[1:0], i_sclk};
         cs_q   <= {cs_q[1:0], i_cs_n};
         si_q   <= {si_q[0], i_si};
         vld_q  <= {vld_q[0], 1'b1};
         arm_q  <= arm_q | (vld_q[1] & cs_q[1]);
         hdr_q  <= 1'b0;
         end_q  <= 1'b0;
         ld_q   <= 1'b0;
         rd_q   <= ld_q;
         if (cs_rise) begin
            end_q   <= (state_q != IDLE);
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            so_q    <= 1'b0;
            rd_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (cs_fall) begin
                     state_q <= CMD;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     sh_q <= shin[22:0];
                     if (cnt_q == 6'd7) begin
                        cmd_q   <= shin[7:0];
                        cnt_q   <= '0;
                        state_q <= (shin[7:0] == RD_CMD) ? ADDR : IGNORE;
                     end else begin
                        cnt_q <= cnt_q + 6'd1;
                     end
                  end
               end
               ADDR: begin
                  if (sclk_rise) begin
                     sh_q <= shin[22:0];
                     if (cnt_q == 6'd23) begin
                        addr_q <= shin;
                        hdr_q  <= 1'b1;
                        rd_q   <= 1'b1;
                        if (DUM_NUM != 0) begin
                           state_q <= DUMMY;
                           cnt_q   <= '0;
                        end else begin
                           state_q <= DATA;
                           oe_q    <= 1'b1;
                           cnt_q   <= 6'd7;
                        end
                     end else begin
                        cnt_q <= cnt_q + 6'd1;
                     end
                  end
               end
               DUMMY: begin
                  if (sclk_rise) begin
                     if (cnt_q == DUM_LAST) begin
                        state_q <= DATA;
                        oe_q    <= 1'b1;
                        cnt_q   <= 6'd7;
                     end else begin
                        cnt_q <= cnt_q + 6'd1;
                     end
                  end
               end
               DATA: begin
                  // cnt_q==7 means the current byte is exhausted: reload
                  if (sclk_fall) begin
                     if (cnt_q == 6'd7) begin
                        out_q <= i_rd_data;
                        so_q  <= i_rd_data[7];
                        ld_q  <= 1'b1;
                        cnt_q <= '0;
                     end else begin
                        out_q <= {out_q[6:0], 1'b0};
                        so_q  <= out_q[6];
                        cnt_q <= cnt_q + 6'd1;
                     end
                  end
               end
               IGNORE: begin
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign o_so      = so_q;
   assign o_so_oe   = oe_q;
   assign o_cmd     = cmd_q;
   assign o_addr    = addr_q;
   assign o_hdr_vld = hdr_q;
   assign o_rd_req  = rd_q;
   assign o_busy    = busy_q;
   assign o_end     = end_q;

endmodule

// File: tb/tb_x1spi_slv.sv
// Testbench for x1spi_slv: SPI master model, read-data responder and
// scoreboard of bytes expected on MISO.
module tb_x1spi_slv;

   logic        i_clk;
   logic        i_rst;
   logic        i_sclk;
   logic        i_cs_n;
   logic        i_si;
   logic        o_so;
   logic        o_so_oe;
   logic [7:0]  o_cmd;
   logic [23:0] o_addr;
   logic        o_hdr_vld;
   logic        o_rd_req;
   logic [7:0]  i_rd_data;
   logic        o_busy;
   logic        o_end;

   logic        o_so0;
   logic        o_so_oe0;
   logic [7:0]  o_cmd0;
   logic [23:0] o_addr0;
   logic        o_hdr_vld0;
   logic        o_rd_req0;
   logic [7:0]  i_rd_data0;
   logic        o_busy0;
   logic        o_end0;

   int checks = 0;
   int fails  = 0;
   int hdr_cnt, rd_cnt, end_cnt;
   logic oe_seen;
   logic busy_pre;
   logic [63:0] miso_sr, miso0_sr;
   logic [7:0] src_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] exp0_q[$];

   x1spi_slv #(.RD_CMD(8'hAA), .DUM_NUM(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_cs_n(i_cs_n),
      .i_si(i_si), .o_so(o_so), .o_so_oe(o_so_oe), .o_cmd(o_cmd),
      .o_addr(o_addr), .o_hdr_vld(o_hdr_vld), .o_rd_req(o_rd_req),
      .i_rd_data(i_rd_data), .o_busy(o_busy), .o_end(o_end)
   );

   x1spi_slv #(.RD_CMD(8'hAA), .DUM_NUM(0)) dut0 (
      .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_cs_n(i_cs_n),
      .i_si(i_si), .o_so(o_so0), .o_so_oe(o_so_oe0), .o_cmd(o_cmd0),
      .o_addr(o_addr0), .o_hdr_vld(o_hdr_vld0), .o_rd_req(o_rd_req0),
      .i_rd_data(i_rd_data0), .o_busy(o_busy0), .o_end(o_end0)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_hdr_vld) hdr_cnt++;
         if (o_end) end_cnt++;
         if (o_so_oe) oe_seen = 1'b1;
         if (o_rd_req) begin
            rd_cnt++;
            if (src_q.size() > 0) begin
               i_rd_data = src_q.pop_front();
               exp_q.push_back(i_rd_data);
            end
         end
      end
   end

   task automatic clr();
      hdr_cnt = 0;
      rd_cnt  = 0;
      end_cnt = 0;
      oe_seen = 1'b0;
      src_q.delete();
      exp_q.delete();
      exp0_q.delete();
   endtask

   task automatic clk_bit(input logic b);
      i_sclk = 1'b0;
      i_si   = b;
      #50;
      i_sclk = 1'b1;
      miso_sr  = {miso_sr[62:0], o_so};
      miso0_sr = {miso0_sr[62:0], o_so0};
      #50;
   endtask

   task automatic end_xfer();
      #20;
      busy_pre = o_busy;
      i_cs_n = 1'b1;
      #100;
      i_sclk = 1'b0;
      #100;
   endtask

   task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr,
                       input int abits, input int dclks, input int nd);
      i_cs_n = 1'b0;
      #100;
      for (int i = 0; i < 8; i++) clk_bit(cmd[7-i]);
      for (int i = 0; i < abits; i++) clk_bit(addr[23-i]);
      for (int i = 0; i < dclks; i++) clk_bit(1'($urandom_range(0, 1)));
      for (int i = 0; i < nd; i++) clk_bit(1'($urandom_range(0, 1)));
      end_xfer();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_cs_n = 1'b1;
      i_sclk = 1'b0;
      i_si = 1'b0;
      i_rd_data = 8'h00;
      i_rd_data0 = 8'h00;
      clr();
      #30;
      checks++;
      if ({o_so, o_so_oe, o_hdr_vld, o_rd_req, o_busy, o_end} !== 6'b0) begin
         fails++;
         $display("FAIL rst_flags got=%b want=000000",
                  {o_so, o_so_oe, o_hdr_vld, o_rd_req, o_busy, o_end});
      end
      checks++;
      if (o_cmd !== 8'h00) begin
         fails++;
         $display("FAIL rst_cmd got=%h want=00", o_cmd);
      end
      checks++;
      if (o_addr !== 24'h0) begin
         fails++;
         $display("FAIL rst_addr got=%h want=000000", o_addr);
      end
      i_rst = 1'b0;
      #100;
      checks++;
      if (o_busy !== 1'b0 || end_cnt != 0) begin
         fails++;
         $display("FAIL rst_idle busy=%b end=%0d want 0/0", o_busy, end_cnt);
      end
   endtask

   task automatic test_trunc();
      clr();
      xfer(8'hAA, 24'hFFFFFF, 12, 0, 0);
      checks++;
      if (o_addr !== 24'h0) begin
         fails++;
         $display("FAIL trunc_addr got=%h want=000000", o_addr);
      end
      checks++;
      if (hdr_cnt != 0) begin
         fails++;
         $display("FAIL trunc_hdr got=%0d want=0", hdr_cnt);
      end
      checks++;
      if (end_cnt != 1) begin
         fails++;
         $display("FAIL trunc_end got=%0d want=1", end_cnt);
      end
      checks++;
      if (o_busy !== 1'b0 || busy_pre !== 1'b1) begin
         fails++;
         $display("FAIL trunc_busy pre=%b post=%b want 1/0", busy_pre, o_busy);
      end
      checks++;
      if (o_cmd !== 8'hAA) begin
         fails++;
         $display("FAIL trunc_cmd got=%h want=aa", o_cmd);
      end
   endtask

   task automatic test_read(input logic [23:0] addr,
                            input logic [7:0] b0, input logic [7:0] b1);
      logic [7:0] e;
      clr();
      src_q.push_back(b0);
      src_q.push_back(b1);
      src_q.push_back(8'h00);
      xfer(8'hAA, addr, 24, 24, 16);
      checks++;
      if (o_cmd !== 8'hAA) begin
         fails++;
         $display("FAIL rd_cmd got=%h want=aa", o_cmd);
      end
      checks++;
      if (o_addr !== addr) begin
         fails++;
         $display("FAIL rd_addr got=%h want=%h", o_addr, addr);
      end
      checks++;
      if (hdr_cnt != 1) begin
         fails++;
         $display("FAIL rd_hdr got=%0d want=1", hdr_cnt);
      end
      checks++;
      if (rd_cnt != 3) begin
         fails++;
         $display("FAIL rd_req got=%0d want=3", rd_cnt);
      end
      checks++;
      if (end_cnt != 1) begin
         fails++;
         $display("FAIL rd_end got=%0d want=1", end_cnt);
      end
      for (int k = 0; k < 2; k++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         checks++;
         if (miso_sr[15-8*k -: 8] !== e) begin
            fails++;
            $display("FAIL rd_miso%0d got=%h want=%h", k, miso_sr[15-8*k -: 8], e);
         end
      end
   endtask

   task automatic test_ignore();
      clr();
      src_q.push_back(8'hFF);
      xfer(8'h03, 24'h123456, 24, 8, 8);
      checks++;
      if (o_cmd !== 8'h03) begin
         fails++;
         $display("FAIL ign_cmd got=%h want=03", o_cmd);
      end
      checks++;
      if (busy_pre !== 1'b1) begin
         fails++;
         $display("FAIL ign_busy got=%b want=1", busy_pre);
      end
      checks++;
      if (hdr_cnt != 0 || rd_cnt != 0) begin
         fails++;
         $display("FAIL ign_pulses hdr=%0d rd=%0d want 0/0", hdr_cnt, rd_cnt);
      end
      checks++;
      if (oe_seen !== 1'b0) begin
         fails++;
         $display("FAIL ign_oe got=%b want=0", oe_seen);
      end
      checks++;
      if (end_cnt != 1) begin
         fails++;
         $display("FAIL ign_end got=%0d want=1", end_cnt);
      end
      checks++;
      if (o_addr !== 24'h555555) begin
         fails++;
         $display("FAIL ign_addr got=%h want=555555", o_addr);
      end
   endtask

   task automatic test_dum0();
      logic [7:0]  e;
      logic [23:0] a;
      clr();
      a = 24'h0F0F0F;
      i_rd_data0 = 8'hC5;
      exp0_q.push_back(i_rd_data0);
      i_cs_n = 1'b0;
      #100;
      for (int i = 0; i < 8; i++) clk_bit(e_bit(8'hAA, 7 - i));
      for (int i = 0; i < 24; i++) clk_bit(a[23-i]);
      checks++;
      if (o_so_oe0 !== 1'b1 || o_so0 !== 1'b0) begin
         fails++;
         $display("FAIL d0_enter oe=%b so=%b want 1/0", o_so_oe0, o_so0);
      end
      checks++;
      if (o_so_oe !== 1'b0) begin
         fails++;
         $display("FAIL d0_ref_oe got=%b want=0", o_so_oe);
      end
      for (int i = 0; i < 8; i++) clk_bit(1'b0);
      e = exp0_q.pop_front();
      checks++;
      if (miso0_sr[7:0] !== e) begin
         fails++;
         $display("FAIL d0_miso got=%h want=%h", miso0_sr[7:0], e);
      end
      checks++;
      if (o_addr0 !== a) begin
         fails++;
         $display("FAIL d0_addr got=%h want=%h", o_addr0, a);
      end
      end_xfer();
   endtask

   function automatic logic e_bit(input logic [7:0] v, input int i);
      return v[i];
   endfunction

   task automatic test_rst_mid();
      clr();
      src_q.push_back(8'h96);
      i_cs_n = 1'b0;
      #100;
      for (int i = 0; i < 8; i++) clk_bit(e_bit(8'hAA, 7 - i));
      for (int i = 0; i < 56; i++) clk_bit(1'b1);
      checks++;
      if (o_so_oe !== 1'b1) begin
         fails++;
         $display("FAIL rm_pre_oe got=%b want=1", o_so_oe);
      end
      i_rst = 1'b1;
      #30;
      checks++;
      if ({o_so, o_so_oe, o_hdr_vld, o_rd_req, o_busy, o_end} !== 6'b0) begin
         fails++;
         $display("FAIL rm_flags got=%b want=000000",
                  {o_so, o_so_oe, o_hdr_vld, o_rd_req, o_busy, o_end});
      end
      checks++;
      if (o_cmd !== 8'h00 || o_addr !== 24'h0) begin
         fails++;
         $display("FAIL rm_regs cmd=%h addr=%h want 00/000000", o_cmd, o_addr);
      end
      i_rst = 1'b0;
      clr();
      #50;
      for (int i = 0; i < 8; i++) clk_bit(e_bit(8'hAA, 7 - i));
      checks++;
      if (o_busy !== 1'b0 || o_cmd !== 8'h00) begin
         fails++;
         $display("FAIL rm_stay_idle busy=%b cmd=%h want 0/00", o_busy, o_cmd);
      end
      end_xfer();
      checks++;
      if (end_cnt != 0) begin
         fails++;
         $display("FAIL rm_no_end got=%0d want=0", end_cnt);
      end
      test_read(24'hABCDEF, 8'h3C, 8'h81);
   endtask

   initial begin
      miso_sr  = '0;
      miso0_sr = '0;
      busy_pre = 1'b0;
      test_reset();
      test_trunc();
      test_read(24'h555555, 8'h5A, 8'hC3);
      test_ignore();
      test_dum0();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
